// File: rtl/lcd_pkg.sv
// Shared definitions for the graphic-LCD parallel bus: command opcodes, address FSM
// states and the frame-buffer address layout. Also used by the LCD bus masters.
package lcd_pkg;

  localparam int FB_AW = 10;

  localparam logic [7:0] FUNC_SET_MASK  = 8'hE0;
  localparam logic [7:0] FUNC_SET       = 8'h20;
  localparam logic [7:0] CLEAR          = 8'h01;
  localparam logic [7:0] DISP_CTRL_MASK = 8'hF8;
  localparam logic [7:0] DISP_CTRL      = 8'h08;
  localparam logic [7:0] ADDR_SET_MASK  = 8'h80;
  localparam logic [7:0] ADDR_SET       = 8'h80;

  localparam int RE_BIT = 2;
  localparam int G_BIT  = 1;
  localparam int D_BIT  = 2;

  typedef enum logic [1:0] {
    WAIT_Y,
    GOT_Y,
    READY
  } addr_state_e;

  function automatic logic is_cmd(input logic [7:0] d, input logic [7:0] mask,
                                  input logic [7:0] op);
    return (d & mask) == op;
  endfunction

  // Frame-buffer byte index: column pair x, row y, half hl (0 = high byte).
  function automatic logic [FB_AW-1:0] fb_index(input logic [3:0] x, input logic [4:0] y,
                                                input logic hl);
    return {x, y, hl};
  endfunction

endpackage

// File: rtl/lcd_gdram_receiver_if.sv
// 8-bit parallel LCD write bus (rs/rw/en/data). The master drives, the receiver listens.
interface lcd_gdram_receiver_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;

  modport master (output lcd_rs, lcd_rw, lcd_en, lcd_data);
  modport slave  (input  lcd_rs, lcd_rw, lcd_en, lcd_data);
endinterface

// File: rtl/lcd_strobe_sync.sv
// Brings the asynchronous lcd_en into the clock domain, captures rs/rw/data while en
// is high and emits a one-cycle strobe on the synchronised falling edge of en.
module lcd_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       en_raw,
  input  logic       rs_raw,
  input  logic       rw_raw,
  input  logic [7:0] data_raw,
  output logic       strobe,
  output logic       rs,
  output logic       rw,
  output logic [7:0] data
);

  logic [SYNC_STAGES-1:0] en_sync;
  logic                   en_prev;
  logic                   en_s;

  assign en_s   = en_sync[SYNC_STAGES-1];
  assign strobe = en_prev & ~en_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      en_sync <= '0;
      en_prev <= 1'b0;
      rs      <= 1'b0;
      rw      <= 1'b0;
      data    <= '0;
    end else begin
      en_sync <= {en_sync[SYNC_STAGES-2:0], en_raw};
      en_prev <= en_s;
      // The bus holds rs/rw/data stable through the whole en-high window, so the
      // last capture before the strobe is the value being transferred.
      if (en_s) begin
        rs   <= rs_raw;
        rw   <= rw_raw;
        data <= data_raw;
      end
    end
  end

endmodule

// File: rtl/lcd_gdram_receiver.sv
// LCD bus responder: decodes commands, tracks the GDRAM X/Y address and writes bytes
// into a 128x64 mono frame buffer; also runs the 1024-cycle clear sequence.
module lcd_gdram_receiver
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 rst_n,
  lcd_gdram_receiver_if.slave  lcd,
  output logic                 fb_we,
  output logic [FB_AW-1:0]     fb_addr,
  output logic [7:0]           fb_wdata,
  output logic                 busy,
  output logic                 ext_mode,
  output logic                 gfx_on,
  output logic                 disp_on,
  output logic                 frame_done,
  output logic                 err_proto,
  output logic                 err_overrun
);

  logic       strobe;
  logic       s_rs;
  logic       s_rw;
  logic [7:0] s_data;

  lcd_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock    (clock),
    .rst_n    (rst_n),
    .en_raw   (lcd.lcd_en),
    .rs_raw   (lcd.lcd_rs),
    .rw_raw   (lcd.lcd_rw),
    .data_raw (lcd.lcd_data),
    .strobe   (strobe),
    .rs       (s_rs),
    .rw       (s_rw),
    .data     (s_data)
  );

  addr_state_e      st_q, st_d;
  logic [3:0]       x_q, x_d;
  logic [4:0]       y_q, y_d;
  logic             hl_q, hl_d;
  logic             fb_we_d, busy_d, ext_d, gfx_d, disp_d, frame_d, ep_d, eo_d;
  logic [FB_AW-1:0] fb_addr_d;
  logic [7:0]       fb_wdata_d;

  // NOTE: every signal gets a default first, so no path through this block can infer a latch.
  always_comb begin
    st_d       = st_q;
    x_d        = x_q;
    y_d        = y_q;
    hl_d       = hl_q;
    fb_we_d    = 1'b0;
    fb_addr_d  = fb_addr;
    fb_wdata_d = fb_wdata;
    busy_d     = busy;
    ext_d      = ext_mode;
    gfx_d      = gfx_on;
    disp_d     = disp_on;
    frame_d    = 1'b0;
    ep_d       = err_proto;
    eo_d       = err_overrun;

    if (busy) begin
      // The clear walks fb_addr itself; the write of 3FF is the last busy cycle.
      if (fb_addr == '1) begin
        busy_d = 1'b0;
        x_d    = '0;
        y_d    = '0;
        hl_d   = 1'b0;
        st_d   = WAIT_Y;
      end else begin
        fb_we_d   = 1'b1;
        fb_addr_d = fb_addr + 1'b1;
      end
      if (strobe) eo_d = 1'b1;
    end else if (strobe) begin
      if (s_rw) begin
        ep_d = 1'b1;
      end else if (s_rs) begin
        if (st_q == READY) begin
          fb_we_d    = 1'b1;
          fb_addr_d  = fb_index(x_q, y_q, hl_q);
          fb_wdata_d = s_data;
          frame_d    = (fb_index(x_q, y_q, hl_q) == '1);
          hl_d       = ~hl_q;
          if (hl_q) x_d = x_q + 1'b1;
        end else begin
          ep_d = 1'b1;
        end
      end else if (is_cmd(s_data, FUNC_SET_MASK, FUNC_SET)) begin
        ext_d = s_data[RE_BIT];
        if (s_data[RE_BIT]) gfx_d = s_data[G_BIT];
        else                st_d  = WAIT_Y;
      end else if (ext_mode && is_cmd(s_data, ADDR_SET_MASK, ADDR_SET)) begin
        // In READY an address byte starts a new Y/X pair.
        unique case (st_q)
          GOT_Y: begin
            x_d  = s_data[3:0];
            hl_d = 1'b0;
            st_d = READY;
          end
          default: begin
            y_d  = s_data[4:0];
            st_d = GOT_Y;
          end
        endcase
      end else if (!ext_mode && s_data == CLEAR) begin
        busy_d     = 1'b1;
        fb_we_d    = 1'b1;
        fb_addr_d  = '0;
        fb_wdata_d = '0;
      end else if (!ext_mode && is_cmd(s_data, DISP_CTRL_MASK, DISP_CTRL)) begin
        disp_d = s_data[D_BIT];
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= WAIT_Y;
      x_q         <= '0;
      y_q         <= '0;
      hl_q        <= 1'b0;
      fb_we       <= 1'b0;
      fb_addr     <= '0;
      fb_wdata    <= '0;
      busy        <= 1'b0;
      ext_mode    <= 1'b0;
      gfx_on      <= 1'b0;
      disp_on     <= 1'b0;
      frame_done  <= 1'b0;
      err_proto   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      st_q        <= st_d;
      x_q         <= x_d;
      y_q         <= y_d;
      hl_q        <= hl_d;
      fb_we       <= fb_we_d;
      fb_addr     <= fb_addr_d;
      fb_wdata    <= fb_wdata_d;
      busy        <= busy_d;
      ext_mode    <= ext_d;
      gfx_on      <= gfx_d;
      disp_on     <= disp_d;
      frame_done  <= frame_d;
      err_proto   <= ep_d;
      err_overrun <= eo_d;
    end
  end

endmodule

// File: tb/tb_lcd_gdram_receiver.sv
// Directed bench for lcd_gdram_receiver: drives the LCD bus, scoreboards frame-buffer
// writes against expected {addr,data,frame_done} entries and checks status flags.
module tb_lcd_gdram_receiver;

  localparam int EN_HI = 10;
  localparam int EN_LO = 10;

  logic clock = 1'b0;
  logic rst_n = 1'b0;

  lcd_gdram_receiver_if bus ();

  logic       fb_we;
  logic [9:0] fb_addr;
  logic [7:0] fb_wdata;
  logic       busy, ext_mode, gfx_on, disp_on, frame_done, err_proto, err_overrun;

  lcd_gdram_receiver #(.SYNC_STAGES(2)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .lcd         (bus.slave),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_wdata    (fb_wdata),
    .busy        (busy),
    .ext_mode    (ext_mode),
    .gfx_on      (gfx_on),
    .disp_on     (disp_on),
    .frame_done  (frame_done),
    .err_proto   (err_proto),
    .err_overrun (err_overrun)
  );

  always #10 clock = ~clock;

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
    logic       fd;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp       = 0;
  int  n_err       = 0;
  int  busy_cycles = 0;
  int  fd_count    = 0;
  int  fd_base     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({fb_we, fb_addr, fb_wdata, busy, ext_mode, gfx_on, disp_on,
                frame_done, err_proto, err_overrun});
  endfunction

  // Write monitor: every fb_we must match the head of the scoreboard.
  always @(negedge clock) begin
    if (busy === 1'b1) busy_cycles++;
    if (frame_done === 1'b1) fd_count++;
    if (frame_done === 1'b1 && fb_we !== 1'b1)
      check("frame_done_without_we", 32'(fb_we), 32'd1);
    if (fb_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_fb_we", 32'(fb_we), 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("fb_write", 32'({fb_addr, fb_wdata, frame_done}), 32'(e));
      end
    end
  end

  task automatic send(input logic rs, input logic rw, input logic [7:0] d);
    @(posedge clock);
    #3;
    bus.lcd_rs   = rs;
    bus.lcd_rw   = rw;
    bus.lcd_data = d;
    bus.lcd_en   = 1'b1;
    repeat (EN_HI) @(posedge clock);
    #7 bus.lcd_en = 1'b0;
    repeat (EN_LO) @(posedge clock);
    #5;
  endtask

  task automatic cmd(input logic [7:0] d);
    send(1'b0, 1'b0, d);
  endtask

  task automatic dat(input logic [7:0] d);
    send(1'b1, 1'b0, d);
  endtask

  task automatic expect_write(input logic [9:0] a, input logic [7:0] d, input logic fd);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.fd   = fd;
    exp_q.push_back(e);
  endtask

  task automatic push_clear();
    for (int i = 0; i < 1024; i++) expect_write(10'(i), 8'h00, 1'b0);
  endtask

  task automatic apply_reset();
    @(posedge clock);
    #5 rst_n = 1'b0;
    #2 check("reset_outputs", all_outs(), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clock);
    #5 rst_n = 1'b1;
    repeat (2) @(posedge clock);
    #5;
  endtask

  task automatic wait_clear_done();
    for (int i = 0; i < 1200 && busy !== 1'b0; i++) @(posedge clock);
    #5 check("clear_finished", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.lcd_en   = 1'b0;
    bus.lcd_rs   = 1'b0;
    bus.lcd_rw   = 1'b0;
    bus.lcd_data = 8'h00;
    repeat (3) @(posedge clock);
    #5 check("reset_outputs", all_outs(), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clock);

    // Basic instruction set: display on, entry mode ignored.
    cmd(8'h30);
    cmd(8'h06);
    cmd(8'h0C);
    check("t1_disp_on", 32'(disp_on), 32'd1);
    check("t1_ext_mode", 32'(ext_mode), 32'd0);
    check("t1_gfx_on", 32'(gfx_on), 32'd0);
    check("t1_errors", 32'({err_proto, err_overrun, busy}), 32'd0);

    // Extended mode, Y=5 X=3, three data bytes (third lands at x=4).
    cmd(8'h36);
    check("t2_ext_mode", 32'(ext_mode), 32'd1);
    check("t2_gfx_on", 32'(gfx_on), 32'd1);
    cmd(8'h85);
    cmd(8'h83);
    expect_write(10'h0CA, 8'hA5, 1'b0);
    dat(8'hA5);
    expect_write(10'h0CB, 8'h5A, 1'b0);
    dat(8'h5A);
    expect_write(10'h10A, 8'h3C, 1'b0);
    dat(8'h3C);
    check("t2_writes_done", 32'(exp_q.size()), 32'd0);

    // Last frame position, frame_done pulse and x wrap 15 -> 0.
    cmd(8'h9F);
    cmd(8'h8F);
    fd_base = fd_count;
    expect_write(10'h3FE, 8'h11, 1'b0);
    dat(8'h11);
    expect_write(10'h3FF, 8'h22, 1'b1);
    dat(8'h22);
    check("t3_frame_done_count", 32'(fd_count - fd_base), 32'd1);
    expect_write(10'h03E, 8'h33, 1'b0);
    dat(8'h33);
    check("t3_writes_done", 32'(exp_q.size()), 32'd0);
    check("t3_err_proto", 32'(err_proto), 32'd0);

    // Clear: back to basic mode, G held, then a second clear arrives while busy.
    cmd(8'h30);
    check("t4_ext_mode", 32'(ext_mode), 32'd0);
    check("t4_gfx_held", 32'(gfx_on), 32'd1);
    busy_cycles = 0;
    fd_base     = fd_count;
    push_clear();
    cmd(8'h01);
    check("t4_busy", 32'(busy), 32'd1);
    cmd(8'h01);
    check("t4_err_overrun", 32'(err_overrun), 32'd1);
    wait_clear_done();
    check("t4_busy_cycles", 32'(busy_cycles), 32'd1024);
    check("t4_writes_done", 32'(exp_q.size()), 32'd0);
    check("t4_no_frame_done", 32'(fd_count - fd_base), 32'd0);
    check("t4_err_proto", 32'(err_proto), 32'd0);
    check("t4_disp_held", 32'(disp_on), 32'd1);

    // Data without an address, then a read strobe after a fresh reset.
    dat(8'h77);
    check("t5_data_no_addr", 32'(err_proto), 32'd1);
    apply_reset();
    send(1'b0, 1'b1, 8'h36);
    check("t5_read_strobe", 32'(err_proto), 32'd1);
    check("t5_read_ignored", 32'({ext_mode, gfx_on}), 32'd0);

    // Reset in the middle of a clear.
    push_clear();
    cmd(8'h01);
    for (int i = 0; i < 1200; i++) begin
      @(negedge clock);
      if (fb_we === 1'b1 && fb_addr === 10'h200) break;
    end
    check("t6_reach_mid_clear", 32'(fb_addr), 32'h200);
    #2 rst_n = 1'b0;
    #1 check("t6_outputs_in_reset", all_outs(), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clock);
    #5 rst_n = 1'b1;
    repeat (100) @(posedge clock);
    #5 check("t6_busy_after_reset", 32'(busy), 32'd0);

    // FSM must be in WAIT_Y: the first address byte is a Y, so data is refused.
    cmd(8'h36);
    cmd(8'h82);
    dat(8'h99);
    check("t6_wait_y_refuses_data", 32'(err_proto), 32'd1);
    cmd(8'h81);
    expect_write(10'h044, 8'h44, 1'b0);
    dat(8'h44);
    check("t6_writes_done", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
